// File: rtl/snn_interfaces_pkg.sv
// Shared SNN interface types. Event geometry and FIFO defaults used by
// the event capture path and the convolution stage that consumes it.
package snn_interfaces_pkg;

  localparam int DEFAULT_COORD_BITS       = 4;
  localparam int DEFAULT_IN_CHANNELS      = 4;
  localparam int DEFAULT_IMG_WIDTH        = 8;
  localparam int DEFAULT_IMG_HEIGHT       = 8;
  localparam int DEFAULT_EVENT_FIFO_DEPTH = 16;

  typedef logic [DEFAULT_IN_CHANNELS-1:0] spike_vector_t;

  typedef struct packed {
    logic [DEFAULT_COORD_BITS-1:0] x;
    logic [DEFAULT_COORD_BITS-1:0] y;
  } vec2_t;

  // One spike event: position followed by the per-channel spike vector.
  typedef struct packed {
    vec2_t         pos;
    spike_vector_t spikes;
  } output_vector_t;

endpackage

// File: rtl/event_fifo_mem.sv
// Event storage for event_capture_fifo: one synchronous write port and
// one asynchronous (combinational) read port.
module event_fifo_mem
  import snn_interfaces_pkg::*;
#(
  parameter int DEPTH = DEFAULT_EVENT_FIFO_DEPTH,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  output_vector_t       wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output output_vector_t       rdata
);

  output_vector_t mem [DEPTH];

  // Write port: store one entry per cycle when enabled.
  // NOTE: the array has no reset; validity is tracked by the owner's
  // count, so resetting storage would only cost a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/event_capture_fifo.sv
// Event capture FIFO: filters malformed spike events, buffers the rest and
// presents them first-word-fall-through to the convolution stage.
// Optional feature: define EVENT_CAPTURE_MERGE_EN to OR spikes of a push
// into the tail entry when it hits the same (x, y) and count >= 2.
// COORD_BITS / IN_CHANNELS must match the widths of output_vector_t.
module event_capture_fifo
  import snn_interfaces_pkg::*;
#(
  parameter int COORD_BITS  = DEFAULT_COORD_BITS,
  parameter int IN_CHANNELS = DEFAULT_IN_CHANNELS,
  parameter int IMG_WIDTH   = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT  = DEFAULT_IMG_HEIGHT,
  parameter int FIFO_DEPTH  = DEFAULT_EVENT_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [COORD_BITS-1:0]       in_x,
  input  logic [COORD_BITS-1:0]       in_y,
  input  logic [IN_CHANNELS-1:0]      in_spikes,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output output_vector_t              event_out,
  output logic                        event_valid,
  input  logic                        event_ack,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [15:0]                 drop_count
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  logic [PTR_BITS-1:0] wr_ptr, rd_ptr, wr_next, rd_next, wr_addr;
  logic [CNT_BITS-1:0] count, count_next;
  output_vector_t      in_event, wr_data, head_data;
  logic                malformed, full, merge_hit, accept;
  logic                do_write, push_new, do_pop, drop_inc;

  assign in_event  = '{pos: '{x: in_x, y: in_y}, spikes: in_spikes};
  assign malformed = (in_spikes == '0) || (int'(in_x) >= IMG_WIDTH) ||
                     (int'(in_y) >= IMG_HEIGHT);
  assign full      = (count == CNT_BITS'(FIFO_DEPTH));

`ifdef EVENT_CAPTURE_MERGE_EN
  output_vector_t tail;

  // A merge never touches the head because it needs at least two entries.
  assign merge_hit = in_valid && !malformed && (count >= CNT_BITS'(2)) &&
                     (in_event.pos == tail.pos);
  assign in_ready  = !full || merge_hit;
  assign wr_data   = merge_hit ? '{pos: tail.pos, spikes: tail.spikes | in_spikes}
                               : in_event;

  // Shadow copy of the most recently written entry, used for merge compares.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        tail <= '0;
    else if (do_write) tail <= wr_data;
  end
`else
  assign merge_hit = 1'b0;
  assign in_ready  = !full;
  assign wr_data   = in_event;
`endif

  assign accept   = in_valid && in_ready;
  assign do_write = accept && !malformed && !flush;
  assign push_new = do_write && !merge_hit;
  assign do_pop   = event_ack && event_valid && !flush;
  assign drop_inc = accept && malformed && !flush;
  assign wr_addr  = merge_hit ? wr_ptr - PTR_BITS'(1) : wr_ptr;

  // Next pointer/count values; flush wins over any push or pop.
  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wr_next    = wr_ptr;
    rd_next    = rd_ptr;
    count_next = count;
    if (flush) begin
      wr_next    = '0;
      rd_next    = '0;
      count_next = '0;
    end else begin
      if (push_new) wr_next = wr_ptr + PTR_BITS'(1);
      if (do_pop)   rd_next = rd_ptr + PTR_BITS'(1);
      if (push_new && !do_pop)      count_next = count + CNT_BITS'(1);
      else if (!push_new && do_pop) count_next = count - CNT_BITS'(1);
    end
  end

  // Pointer and occupancy registers.
  // NOTE: non-blocking assignments keep every register updating from the
  // same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      count  <= count_next;
    end
  end

  // Saturating count of discarded events; survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  drop_count <= '0;
    else if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

  event_fifo_mem #(.DEPTH(FIFO_DEPTH)) u_mem (
    .clk   (clk),
    .we    (do_write),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head_data)
  );

  assign event_valid = (count != '0);
  assign event_out   = event_valid ? head_data : '0;
  assign fifo_count  = count;

endmodule

// File: tb/tb_event_capture_fifo.sv
// Self-checking bench for event_capture_fifo (8x8 image, 4 channels,
// depth 4). Honours EVENT_CAPTURE_MERGE_EN when defined.
module tb_event_capture_fifo;
  import snn_interfaces_pkg::*;

  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     in_x, in_y, in_spikes;
  logic           in_valid, in_ready, flush, event_valid, event_ack;
  output_vector_t event_out;
  logic [2:0]     fifo_count;
  logic [15:0]    drop_count;

  event_capture_fifo #(
    .COORD_BITS(4), .IN_CHANNELS(4), .IMG_WIDTH(8), .IMG_HEIGHT(8), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_x(in_x), .in_y(in_y), .in_spikes(in_spikes),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush), .event_out(event_out),
    .event_valid(event_valid), .event_ack(event_ack), .fifo_count(fifo_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model: queue of events ----------------
  typedef struct { int x; int y; int s; } ev_t;
  ev_t q[$];
  int  m_drop = 0;

  function automatic bit well_formed(input int x, input int y, input int s);
    return s != 0 && x < 8 && y < 8;
  endfunction

  function automatic bit model_merge(input bit v, input int x, input int y, input int s);
`ifdef EVENT_CAPTURE_MERGE_EN
    return v && well_formed(x, y, s) && q.size() >= 2 && q[$].x == x && q[$].y == y;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_ready(input bit v, input int x, input int y, input int s);
    return q.size() < DEPTH || model_merge(v, x, y, s);
  endfunction

  task automatic model_step(input bit v, input int x, input int y, input int s,
                            input bit ack, input bit fl);
    bit mh, ok, pop;
    if (fl) begin
      q.delete();
      return;
    end
    mh  = model_merge(v, x, y, s);
    ok  = v && model_ready(v, x, y, s);
    pop = ack && q.size() > 0;
    if (ok && !well_formed(x, y, s)) begin
      if (m_drop < 65535) m_drop++;
    end else if (ok) begin
      if (mh) q[$].s = q[$].s | s;
      else    q.push_back('{x: x, y: y, s: s});
    end
    if (pop) void'(q.pop_front());
  endtask

  function automatic int pack_ev(input int x, input int y, input int s);
    return (x << 8) | (y << 4) | s;
  endfunction

  task automatic drive(input bit v, input int x, input int y, input int s,
                       input bit ack, input bit fl);
    in_valid = v; in_x = 4'(x); in_y = 4'(y); in_spikes = 4'(s);
    event_ack = ack; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // One model-checked clock cycle; starts and ends just after a rising edge.
  task automatic cycle(input bit v, input int x, input int y, input int s,
                       input bit ack, input bit fl);
    int exp_out;
    drive(v, x, y, s, ack, fl);
    #1;
    check("in_ready", in_ready, model_ready(v, x, y, s));
    model_step(v, x, y, s, ack, fl);
    @(posedge clk); #1;
    exp_out = (q.size() > 0) ? pack_ev(q[0].x, q[0].y, q[0].s) : 0;
    check("event_valid", event_valid, q.size() > 0);
    check("fifo_count", fifo_count, q.size());
    check("drop_count", drop_count, m_drop);
    check("event_out", event_out, exp_out);
  endtask

  // Reset asserted mid-cycle: outputs must clear before the next edge.
  task automatic do_reset();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", event_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ready", in_ready, 1);
    check("rst_out", event_out, 0);
    q.delete();
    m_drop = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit v; int x; int y; int s; bit ack; bit fl;
    bit e_valid; int e_count; int e_drop; int e_out; bit e_ready;
  } vec_t;

  function automatic vec_t mk(input bit v, input int x, input int y, input int s,
                              input bit ack, input bit e_valid, input int e_count,
                              input int e_drop, input int e_out);
    return '{v: v, x: x, y: y, s: s, ack: ack, fl: 1'b0, e_valid: e_valid,
             e_count: e_count, e_drop: e_drop, e_out: e_out, e_ready: 1'b1};
  endfunction

  vec_t vecs[$];

  initial begin
    rst_n = 1'b1;
    idle();
    @(posedge clk); #1;
    do_reset();

    // Single push held without ack, then drained; drops; boundary coords.
    vecs.push_back(mk(1, 2, 3, 4'b0101, 0, 1, 1, 0, 'h235));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 'h235));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 8, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 9, 1, 0, 0, 0, 2, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3, 0));
    vecs.push_back(mk(1, 7, 7, 'hF, 0, 1, 1, 3, 'h77F));
    vecs.push_back(mk(1, 7, 7, 1, 1, 1, 1, 3, 'h771));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 3, 0));
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].ack, vecs[i].fl);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), event_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].e_count);
      check($sformatf("vec%0d_drop", i), drop_count, vecs[i].e_drop);
      check($sformatf("vec%0d_out", i), event_out, vecs[i].e_out);
      check($sformatf("vec%0d_ready", i), in_ready, vecs[i].e_ready);
    end

    // Fill to full, refuse a fifth push, drain in order.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, i, 0, 0);
    idle(); #1;
    check("full_ready", in_ready, 0);
    check("full_count", fifo_count, 4);
    cycle(1, 5, 0, 5, 0, 0);
    check("refused_count", fifo_count, 4);
    idle(); #1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("order%0d", i), event_out, pack_ev(i, 0, i));
      cycle(0, 0, 0, 0, 1, 0);
    end
    check("drained_valid", event_valid, 0);

    // Full with simultaneous push and ack; then push+ack at count 2 across wrap.
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, i, 0, 0);
    cycle(1, 6, 0, 6, 1, 0);
    check("full_push_ack_count", fifo_count, 3);
    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, i % 8, 2 + i / 8, (i % 15) + 1, 1, 0);
      check($sformatf("steady%0d_count", i), fifo_count, 2);
    end
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);

    // Flush with three entries, push and ack in the flush cycle.
    do_reset();
    cycle(1, 9, 9, 1, 0, 0);
    for (int i = 1; i <= 3; i++) cycle(1, i, 2, 3, 0, 0);
    cycle(1, 4, 4, 1, 1, 1);
    check("flush_count", fifo_count, 0);
    check("flush_valid", event_valid, 0);
    check("flush_drop", drop_count, 1);

    // Reset mid-stream with entries present.
    cycle(1, 1, 1, 1, 0, 0);
    cycle(1, 2, 2, 2, 0, 0);
    do_reset();

    // Same-coordinate push behind a distinct head.
    cycle(1, 1, 1, 4'b0001, 0, 0);
    cycle(1, 5, 5, 4'b0010, 0, 0);
    cycle(1, 5, 5, 4'b0100, 0, 0);
`ifdef EVENT_CAPTURE_MERGE_EN
    check("merge_count", fifo_count, 2);
    cycle(0, 0, 0, 0, 1, 0);
    check("merge_head", event_out, 'h556);
`else
    check("nomerge_count", fifo_count, 3);
    cycle(0, 0, 0, 0, 1, 0);
    check("nomerge_head", event_out, 'h552);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    begin
      int lx = 0, ly = 0;
      for (int i = 0; i < 400; i++) begin
        int x, y, s;
        bit v;
        if ($urandom_range(0, 2) == 0) begin
          x = lx; y = ly;
        end else begin
          x = int'($urandom_range(0, 9)); y = int'($urandom_range(0, 9));
        end
        s = int'($urandom_range(0, 15));
        v = ($urandom_range(0, 3) != 0);
        if (v) begin lx = x; ly = y; end
        cycle(v, x, y, s, $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
